// File: rtl/fft256_seq_ctrl.sv
// Sequencer for the 4-bank in-place 256-point FFT datapath: sample load, then
// NSTAGE compute stages with per-cycle addresses, mux selects and twiddle address.
module fft256_seq_ctrl #(
  parameter int ADDR_BIT = 6,
  parameter int NSTAGE   = 7,
  parameter int PIPE_LAT = 2,
  parameter int TW_BIT   = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_BIT-1:0]   load_idx,
  output logic                  m0,
  output logic                  m11,
  output logic [1:0]            m12,
  output logic [1:0]            m13,
  output logic                  m14,
  output logic                  m21,
  output logic                  m22,
  output logic                  m23,
  output logic                  m24,
  output logic                  en,
  output logic                  re,
  output logic                  we,
  output logic [4*ADDR_BIT-1:0] addr_read,
  output logic [4*ADDR_BIT-1:0] addr_write,
  output logic [TW_BIT-1:0]     tw_addr,
  output logic                  bypass_en,
  output logic [3:0]            stage,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // {m11,m12,m13,m14} and {m21,m22,m23,m24} patterns
  localparam logic [5:0] PAT_A = {1'b0, 2'd1, 2'd1, 1'b1};
  localparam logic [5:0] PAT_B = {1'b1, 2'd0, 2'd2, 1'b0};
  localparam logic [5:0] PAT_C = {1'b0, 2'd2, 2'd0, 1'b1};
  localparam logic [3:0] PAT_Q = 4'b0011;
  localparam logic [3:0] PAT_P = 4'b1100;

  localparam logic [ADDR_BIT-1:0] CNT_ONE    = ADDR_BIT'(1);
  localparam logic [ADDR_BIT-1:0] CNT_MAX    = {ADDR_BIT{1'b1}};
  localparam logic [ADDR_BIT-1:0] DRAIN_LAST = ADDR_BIT'(PIPE_LAT - 1);
  localparam logic [3:0]          LAST_STAGE = 4'(NSTAGE);

  function automatic logic [2:0] kbit(input logic [3:0] s);
    case (s)
      4'd1:    kbit = 3'd5;
      4'd2:    kbit = 3'd4;
      4'd3:    kbit = 3'd4;
      4'd4:    kbit = 3'd3;
      4'd5:    kbit = 3'd2;
      4'd6:    kbit = 3'd1;
      4'd7:    kbit = 3'd0;
      default: kbit = 3'd0;
    endcase
  endfunction

  state_t                state_r, state_s;
  logic [ADDR_BIT-1:0]   cnt_r, cnt_s;
  logic [3:0]            stage_r, stage_s;
  logic [2:0]            sel_k_s;
  logic [ADDR_BIT-1:0]   mask_s;
  logic [ADDR_BIT-1:0]   cnt_hi_s;
  logic [TW_BIT-1:0]     tw_base_s;
  logic [5:0]            m1_s;
  logic [3:0]            m2_s;
  logic [PIPE_LAT-1:0]   dly_we_r;
  logic [4*ADDR_BIT-1:0] dly_addr_r [PIPE_LAT];

  assign sel_k_s   = kbit(stage_r);
  assign mask_s    = ~({ADDR_BIT{1'b1}} >> (stage_r - 4'd1));
  assign cnt_hi_s  = cnt_r >> sel_k_s;
  assign tw_base_s = TW_BIT'(cnt_r);
  assign {m11, m12, m13, m14} = m1_s;
  assign {m21, m22, m23, m24} = m2_s;
  assign stage = stage_r;

  // state, counter and stage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
      stage_r <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      stage_r <= stage_s;
    end
  end

  // next-state and counter sequencing
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    stage_s = stage_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_LOAD;
          cnt_s   = '0;
          stage_s = '0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          cnt_s = cnt_r + CNT_ONE;
          if (cnt_r == CNT_MAX) begin
            state_s = S_RUN;
            stage_s = 4'd1;
          end else begin
            state_s = S_LOAD;
          end
        end else begin
          state_s = S_LOAD;
        end
      end
      S_RUN: begin
        if (cnt_r == CNT_MAX) begin
          state_s = S_DRAIN;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      S_DRAIN: begin
        // the drain reuses cnt to wait out the datapath latency
        if (cnt_r == DRAIN_LAST) begin
          cnt_s = '0;
          if (stage_r == LAST_STAGE) begin
            state_s = S_DONE;
          end else begin
            state_s = S_RUN;
            stage_s = stage_r + 4'd1;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
        cnt_s   = '0;
        stage_s = '0;
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = '0;
        stage_s = '0;
      end
    endcase
  end

  // read-side request delayed to the write side of the datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      dly_we_r <= '0;
      for (int i = 0; i < PIPE_LAT; i++) dly_addr_r[i] <= '0;
    end else begin
      dly_we_r[0]   <= re;
      dly_addr_r[0] <= addr_read;
      for (int i = 1; i < PIPE_LAT; i++) begin
        dly_we_r[i]   <= dly_we_r[i-1];
        dly_addr_r[i] <= dly_addr_r[i-1];
      end
    end
  end

  // per-state output decode
  always_comb begin
    in_ready   = 1'b0;
    load_idx   = '0;
    m0         = 1'b0;
    m1_s       = PAT_A;
    m2_s       = PAT_Q;
    en         = 1'b0;
    re         = 1'b0;
    we         = 1'b0;
    addr_read  = '0;
    addr_write = '0;
    tw_addr    = '0;
    bypass_en  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_r)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_LOAD: begin
        busy       = 1'b1;
        en         = 1'b1;
        in_ready   = 1'b1;
        we         = in_valid;
        addr_write = {4{cnt_r}};
        load_idx   = cnt_r;
      end
      S_RUN: begin
        busy       = 1'b1;
        en         = 1'b1;
        m0         = 1'b1;
        re         = 1'b1;
        addr_read  = {cnt_r ^ mask_s, cnt_r ^ mask_s, cnt_r, cnt_r};
        we         = dly_we_r[PIPE_LAT-1];
        addr_write = dly_addr_r[PIPE_LAT-1];
        tw_addr    = tw_base_s << (stage_r - 4'd1);
        bypass_en  = (stage_r <= 4'd3);
        if (cnt_r[sel_k_s]) begin
          m2_s = PAT_P;
        end else begin
          m2_s = PAT_Q;
        end
        if (stage_r == 4'd1) begin
          m1_s = PAT_C;
        end else if (cnt_hi_s == '0) begin
          m1_s = PAT_A;
        end else if (cnt_r[sel_k_s]) begin
          m1_s = PAT_B;
        end else begin
          m1_s = PAT_C;
        end
      end
      S_DRAIN: begin
        busy       = 1'b1;
        en         = 1'b1;
        m0         = 1'b1;
        we         = dly_we_r[PIPE_LAT-1];
        addr_write = dly_addr_r[PIPE_LAT-1];
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fft256_seq_ctrl.sv
// Self-checking bench for fft256_seq_ctrl: random load stalls and ignored inputs,
// checked cycle by cycle against a schedule model built from the sequencing rules.
module tb_fft256_seq_ctrl;
  localparam int PIPE_LAT = 2;

  localparam logic [5:0] PA = 6'b001011;
  localparam logic [5:0] PB = 6'b100100;
  localparam logic [5:0] PC = 6'b010001;
  localparam logic [3:0] PQ = 4'b0011;
  localparam logic [3:0] PP = 4'b1100;

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic        in_ready, m0, m11, m14, m21, m22, m23, m24;
  logic [1:0]  m12, m13;
  logic        en, re, we, bypass_en, busy, done;
  logic [5:0]  load_idx;
  logic [23:0] addr_read, addr_write;
  logic [6:0]  tw_addr;
  logic [3:0]  stage;
  logic [82:0] obs_all;
  logic [82:0] idle_v;

  fft256_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .load_idx(load_idx), .m0(m0), .m11(m11), .m12(m12), .m13(m13), .m14(m14),
    .m21(m21), .m22(m22), .m23(m23), .m24(m24), .en(en), .re(re), .we(we),
    .addr_read(addr_read), .addr_write(addr_write), .tw_addr(tw_addr),
    .bypass_en(bypass_en), .stage(stage), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign obs_all = {in_ready, load_idx, m0, m11, m12, m13, m14, m21, m22, m23, m24,
                    en, re, we, addr_read, addr_write, tw_addr, bypass_en, stage, busy, done};
  assign idle_v  = {1'b0, 6'd0, 1'b0, PA, PQ, 3'b000, 24'd0, 24'd0, 7'd0, 1'b0,
                    4'd0, 1'b0, 1'b0};

  int          errors = 0;
  int          checks = 0;
  int          t;
  int          wq_t[$];
  logic [23:0] wq_a[$];
  int          ktab[8] = '{0, 5, 4, 4, 3, 2, 1, 0};
  int          mtab[8] = '{0, 0, 32, 48, 56, 60, 62, 63};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_write_side();
    logic exp_we;
    exp_we = (wq_t.size() > 0) && (wq_t[0] == t);
    chk("we", we, exp_we);
    if (exp_we) begin
      chk("addr_write", addr_write, wq_a[0]);
      void'(wq_t.pop_front());
      void'(wq_a.pop_front());
    end
  endtask

  // mode: 100 = in_valid held, <0 = alternate 1-0-1, else percent valid
  task automatic do_run(input int mode, input bit extra_start, input int rst_stage,
                        input int rst_cnt);
    int          k, iters, nwr, kb;
    logic [23:0] ar;
    logic [5:0]  e_m1;
    logic [3:0]  e_m2;
    tick();
    start = 1'b1; in_valid = 1'b0;
    #1 chk("idle_before_start", obs_all, idle_v);
    t = 0; k = 0; iters = 0; nwr = 0;
    wq_t.delete(); wq_a.delete();
    while (k < 64 && iters < 4000) begin
      tick(); t++; iters++;
      start = 1'b0;
      if (mode == 100) in_valid = 1'b1;
      else if (mode < 0) in_valid = iters[0];
      else in_valid = ($urandom_range(0, 99) < mode);
      #1;
      chk("load_ready", in_ready, 1'b1);
      chk("load_idx", load_idx, k);
      chk("load_we", we, in_valid);
      chk("load_addr_write", addr_write, {4{k[5:0]}});
      chk("load_m0", m0, 1'b0);
      chk("load_stage", stage, 4'd0);
      chk("load_ctl", {busy, en, re, done}, 4'b1100);
      if (in_valid && we && !m0) nwr++;
      if (in_valid) k++;
    end
    chk("load_complete", k, 64);
    chk("load_writes", nwr, 64);
    for (int s = 1; s <= 7; s++) begin
      for (int c = 0; c < 64; c++) begin
        tick(); t++;
        in_valid = 1'($urandom);
        start = extra_start && (s == 5) && (c == 10);
        #1;
        kb = ktab[s];
        ar = {6'(c ^ mtab[s]), 6'(c ^ mtab[s]), 6'(c), 6'(c)};
        if (s == 1) e_m1 = PC;
        else if (c < (1 << kb)) e_m1 = PA;
        else if (((c >> kb) % 2) == 1) e_m1 = PB;
        else e_m1 = PC;
        e_m2 = (((c >> kb) % 2) == 1) ? PP : PQ;
        chk("run_stage", stage, s);
        chk("run_ctl", {busy, en, re, m0, done, in_ready}, 6'b111100);
        chk("run_addr_read", addr_read, ar);
        chk("run_m1", {m11, m12, m13, m14}, e_m1);
        chk("run_m2", {m21, m22, m23, m24}, e_m2);
        chk("run_tw_addr", tw_addr, (c * (1 << (s - 1))) % 128);
        chk("run_bypass", bypass_en, s <= 3);
        check_write_side();
        wq_t.push_back(t + PIPE_LAT);
        wq_a.push_back(ar);
        if (s == rst_stage && c == rst_cnt) begin
          rst = 1'b1;
          tick();
          #1 chk("after_rst", obs_all, idle_v);
          rst = 1'b0; start = 1'b0;
          return;
        end
      end
      for (int d = 0; d < PIPE_LAT; d++) begin
        tick(); t++;
        start = 1'b0;
        #1;
        chk("drain_stage", stage, s);
        chk("drain_ctl", {busy, re, done}, 3'b100);
        check_write_side();
      end
    end
    tick(); t++;
    start = extra_start;
    #1;
    chk("done_pulse", {done, busy, en}, 3'b100);
    chk("done_queue_empty", wq_t.size(), 0);
    tick();
    start = 1'b0;
    #1 chk("idle_after_done", obs_all, idle_v);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    repeat (3) tick();
    #1 chk("reset_state", obs_all, idle_v);
    rst = 1'b0;
    do_run(100, 1'b0, 0, 0);
    do_run(-1, 1'b0, 0, 0);
    do_run(60, 1'b1, 0, 0);
    do_run(100, 1'b0, 3, 30);
    do_run(100, 1'b0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
